// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the two-requester SRAM port arbiter.
//   - default data / write-mask widths
//   - requester identifiers used to tag read returns
//   - arbiter state encoding
//   - round-robin winner selection helper
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_WMASK_W = DEF_DATA_W / 8;

    // Requester identifiers carried through the read tag pipeline.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } arb_state_e;

    // Winner among the current requests. With both requesting, the one that
    // was not granted last wins. The result is only meaningful when at least
    // one request is present; the caller qualifies it.
    function automatic logic rr_pick(input logic req0, input logic req1,
                                     input logic last_id);
        logic pick;
        if (req0 && req1) begin
            pick = ~last_id;
        end else if (req1) begin
            pick = REQ1;
        end else begin
            pick = REQ0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// sram_rd_tag_pipe
// READ_LAT-deep shift register of {valid, requester id}. One entry is pushed
// every clock (valid=0 for non-read cycles), so the head shows which
// requester, if any, owns the macro read data READ_LAT-1 cycles after the
// read was presented to the macro.
//
// Ports:
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset, clears all valid bits
//   push_valid  in   a read is being issued to the macro next cycle
//   push_id     in   requester id of that read
//   head_valid  out  oldest stage holds a read
//   head_id     out  requester id of the oldest stage
//   empty       out  no stage holds a read
// ---------------------------------------------------------------------------
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_valid,
    input  logic push_id,
    output logic head_valid,
    output logic head_id,
    output logic empty
);

    logic [READ_LAT-1:0] valid_reg;
    logic [READ_LAT-1:0] id_reg;
    logic [READ_LAT-1:0] valid_next;
    logic [READ_LAT-1:0] id_next;

    assign valid_next[0] = push_valid;
    assign id_next[0]    = push_id;

    // Each stage takes the previous one; with READ_LAT=1 there is only the
    // input stage.
    genvar gi;
    generate
        for (gi = 1; gi < READ_LAT; gi++) begin : g_stage
            assign valid_next[gi] = valid_reg[gi-1];
            assign id_next[gi]    = id_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= '0;
            id_reg    <= {READ_LAT{REQ0}};
        end else begin
            valid_reg <= valid_next;
            id_reg    <= id_next;
        end
    end

    assign head_valid = valid_reg[READ_LAT-1];
    assign head_id    = id_reg[READ_LAT-1];
    assign empty      = ~|valid_reg;

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Shares the read/write port 0 of one OpenRAM macro between two requesters
// (0: Wishbone monitor path, 1: test/pattern engine). Grants are
// combinational and round-robin; the chosen command is registered onto the
// macro pins the following cycle. Read data is returned on the shared rdata
// bus READ_LAT cycles after the macro saw the read, qualified by the
// originating requester's rvalid.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   enable               1 = grants allowed, 0 = drain and park deselected
//   rX_req/we/addr/      requester X command (req held until rX_gnt)
//     wdata/wmask
//   rX_gnt               command accepted this cycle
//   rX_rvalid            rdata belongs to requester X this cycle
//   rdata                registered read data, held between returns
//   busy                 state not IDLE or reads still in flight
//   sram_dout            macro dout0
//   csb0/web0/wmask0/    macro port 0 pins (registered)
//     addr0/din0
// ---------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WMASK_W  = DATA_W / 8,
    parameter int READ_LAT = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,

    input  logic               r0_req,
    input  logic               r0_we,
    input  logic [ADDR_W-1:0]  r0_addr,
    input  logic [DATA_W-1:0]  r0_wdata,
    input  logic [WMASK_W-1:0] r0_wmask,
    output logic               r0_gnt,
    output logic               r0_rvalid,

    input  logic               r1_req,
    input  logic               r1_we,
    input  logic [ADDR_W-1:0]  r1_addr,
    input  logic [DATA_W-1:0]  r1_wdata,
    input  logic [WMASK_W-1:0] r1_wmask,
    output logic               r1_gnt,
    output logic               r1_rvalid,

    output logic [DATA_W-1:0]  rdata,
    output logic               busy,

    input  logic [DATA_W-1:0]  sram_dout,
    output logic               csb0,
    output logic               web0,
    output logic [WMASK_W-1:0] wmask0,
    output logic [ADDR_W-1:0]  addr0,
    output logic [DATA_W-1:0]  din0
);

    // ------------------------------------------------------------------
    // State and round-robin pointer
    // ------------------------------------------------------------------
    arb_state_e state_reg, state_next;
    logic       last_reg, last_next;
    logic       grant_ok;
    logic       win_id;
    logic       gnt_any;
    logic       tag_empty;
    logic       head_valid;
    logic       head_id;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            last_reg  <= REQ1;      // so requester 0 wins the first tie
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_ok   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = ACTIVE;
            end
            ACTIVE: begin
                // Grants stop in the very cycle enable falls.
                if (enable) grant_ok   = 1'b1;
                else        state_next = DRAIN;
            end
            DRAIN: begin
                if (enable)         state_next = ACTIVE;
                else if (tag_empty) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign win_id    = rr_pick(r0_req, r1_req, last_reg);
    assign gnt_any   = grant_ok & (r0_req | r1_req);
    assign r0_gnt    = gnt_any & (win_id == REQ0);
    assign r1_gnt    = gnt_any & (win_id == REQ1);
    assign last_next = gnt_any ? win_id : last_reg;

    // ------------------------------------------------------------------
    // Command selection and registered macro pins
    // ------------------------------------------------------------------
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [WMASK_W-1:0] sel_wmask;

    always_comb begin
        if (win_id == REQ1) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
            sel_wmask = r1_wmask;
        end else begin
            sel_we    = r0_we;
            sel_addr  = r0_addr;
            sel_wdata = r0_wdata;
            sel_wmask = r0_wmask;
        end
    end

    logic               csb0_reg;
    logic               web0_reg;
    logic [WMASK_W-1:0] wmask0_reg;
    logic [ADDR_W-1:0]  addr0_reg;
    logic [DATA_W-1:0]  din0_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csb0_reg   <= 1'b1;
            web0_reg   <= 1'b1;
            wmask0_reg <= '0;
            addr0_reg  <= '0;
            din0_reg   <= '0;
        end else if (gnt_any) begin
            csb0_reg   <= 1'b0;
            web0_reg   <= ~sel_we;
            wmask0_reg <= sel_we ? sel_wmask : '0;
            addr0_reg  <= sel_addr;
            din0_reg   <= sel_wdata;
        end else begin
            // Deselect; address and data keep their last values so the
            // macro inputs do not toggle needlessly.
            csb0_reg   <= 1'b1;
            web0_reg   <= 1'b1;
            wmask0_reg <= '0;
        end
    end

    assign csb0   = csb0_reg;
    assign web0   = web0_reg;
    assign wmask0 = wmask0_reg;
    assign addr0  = addr0_reg;
    assign din0   = din0_reg;

    // ------------------------------------------------------------------
    // Read tagging and return
    // ------------------------------------------------------------------
    // The tag is pushed on the same edge that drives csb0 low, so the head
    // stage is valid in the last cycle before the return; the return
    // registers below add the final cycle of latency.
    sram_rd_tag_pipe #(
        .READ_LAT (READ_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .resetn     (resetn),
        .push_valid (gnt_any & ~sel_we),
        .push_id    (win_id),
        .head_valid (head_valid),
        .head_id    (head_id),
        .empty      (tag_empty)
    );

    logic              r0_rvalid_reg;
    logic              r1_rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r0_rvalid_reg <= 1'b0;
            r1_rvalid_reg <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            r0_rvalid_reg <= head_valid & (head_id == REQ0);
            r1_rvalid_reg <= head_valid & (head_id == REQ1);
            if (head_valid) rdata_reg <= sram_dout;
        end
    end

    assign r0_rvalid = r0_rvalid_reg;
    assign r1_rvalid = r1_rvalid_reg;
    assign rdata     = rdata_reg;
    assign busy      = (state_reg != IDLE) | ~tag_empty;

    // ------------------------------------------------------------------
    // Interface protocol checks
    // ------------------------------------------------------------------
    // A requester that lost arbitration while grants were possible must
    // keep its request up.
    a_r0_hold : assert property (@(posedge clk) disable iff (!resetn)
        (r0_req && !r0_gnt && grant_ok) |=> r0_req);
    a_r1_hold : assert property (@(posedge clk) disable iff (!resetn)
        (r1_req && !r1_gnt && grant_ok) |=> r1_req);
    a_one_gnt : assert property (@(posedge clk) disable iff (!resetn)
        !(r0_gnt && r1_gnt));
    a_one_rv  : assert property (@(posedge clk) disable iff (!resetn)
        !(r0_rvalid && r1_rvalid));

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int LAT = 2;
    localparam int NR  = 400;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic [MW-1:0] r0_wmask, r1_wmask;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [DW-1:0] sram_dout;
    logic          csb0, web0;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;

    sram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WMASK_W(MW), .READ_LAT(LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_wmask(r0_wmask), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_wmask(r1_wmask), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .rdata(rdata), .busy(busy), .sram_dout(sram_dout),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wmask = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wmask = '0;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        enable    = 1'b0;
        sram_dout = '0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_csb0", csb0, 1'b1);
        chk1("rst_web0", web0, 1'b1);
        chk32("rst_wmask0", 32'(wmask0), 32'h0);
        chk32("rst_addr0", 32'(addr0), 32'h0);
        chk32("rst_din0", din0, 32'h0);
        chk1("rst_gnt", r0_gnt | r1_gnt, 1'b0);
        chk1("rst_rvalid", r0_rvalid | r1_rvalid, 1'b0);
        chk32("rst_rdata", rdata, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        resetn = 1'b1;
    endtask

    // Table row: enable | r0 req/we, r1 req/we | expected gnt0/gnt1,
    // csb0/web0, rvalid0/rvalid1, busy
    typedef struct packed {
        logic en; logic q0; logic w0; logic q1; logic w1;
        logic g0; logic g1; logic csb; logic web; logic v0; logic v1; logic busy;
    } vec_t;
    vec_t tbl [9];

    // Reference model state for the random phase
    int            rv_id     [NR+LAT+4];
    logic [DW-1:0] dout_hist [NR+LAT+4];
    logic          pend      [2];
    logic          q_we      [2];
    logic [AW-1:0] q_addr    [2];
    logic [DW-1:0] q_wdata   [2];
    logic [MW-1:0] q_wmask   [2];
    int            m_state;      // 0 idle, 1 active, 2 drain
    int            m_last;
    int            g;
    logic          m_empty;
    logic          e_csb, e_web;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [MW-1:0] e_wmask;
    logic [DW-1:0] e_rdata;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = 12'b1_0000_00_11_00_0;
        tbl[1] = 12'b1_1011_10_11_00_1;
        tbl[2] = 12'b1_1011_01_01_00_1;
        tbl[3] = 12'b1_1000_10_00_00_1;
        tbl[4] = 12'b1_0010_01_01_10_1;
        tbl[5] = 12'b1_1100_10_01_00_1;
        tbl[6] = 12'b0_1000_00_00_10_1;
        tbl[7] = 12'b0_0000_00_11_01_1;
        tbl[8] = 12'b0_0000_00_11_00_0;

        // ---------------- table-driven vectors ----------------
        do_reset();
        for (int k = 0; k < 9; k++) begin
            tick();
            enable   = tbl[k].en;
            r0_req   = tbl[k].q0;  r0_we = tbl[k].w0;  r0_addr = 8'h11;
            r0_wdata = 32'h1111_0000; r0_wmask = 4'hF;
            r1_req   = tbl[k].q1;  r1_we = tbl[k].w1;  r1_addr = 8'h22;
            r1_wdata = 32'h2222_0000; r1_wmask = 4'hC;
            sram_dout = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            chk1("tbl_gnt0", r0_gnt, tbl[k].g0);
            chk1("tbl_gnt1", r1_gnt, tbl[k].g1);
            chk1("tbl_csb0", csb0, tbl[k].csb);
            chk1("tbl_web0", web0, tbl[k].web);
            chk1("tbl_rvalid0", r0_rvalid, tbl[k].v0);
            chk1("tbl_rvalid1", r1_rvalid, tbl[k].v1);
            chk1("tbl_busy", busy, tbl[k].busy);
            if (tbl[k].v0 || tbl[k].v1)
                chk32("tbl_rdata", rdata, 32'hA000_0000 + 32'(k - 1));
            $display("row %0d: en=%b gnt=%b%b csb0=%b web0=%b rv=%b%b busy=%b",
                     k, enable, r0_gnt, r1_gnt, csb0, web0, r0_rvalid, r1_rvalid, busy);
        end

        // ---------------- single read, addr 0x10 ----------------
        do_reset();
        enable = 1'b1;
        tick();                                    // IDLE -> ACTIVE
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
        sram_dout = 32'hDEAD_BEEF;
        @(negedge clk); chk1("rd_gnt", r0_gnt, 1'b1);
        tick(); clear_reqs();
        @(negedge clk);
        chk1("rd_csb0", csb0, 1'b0);
        chk1("rd_web0", web0, 1'b1);
        chk32("rd_addr0", 32'(addr0), 32'h10);
        tick(); @(negedge clk); chk1("rd_early_rvalid", r0_rvalid, 1'b0);
        tick(); @(negedge clk);
        chk1("rd_rvalid0", r0_rvalid, 1'b1);
        chk1("rd_rvalid1", r1_rvalid, 1'b0);
        chk32("rd_rdata", rdata, 32'hDEAD_BEEF);
        tick(); @(negedge clk); chk1("rd_rvalid_one_cycle", r0_rvalid, 1'b0);
        $display("read r0 addr=10 data=%h", rdata);

        // ---------------- single write, addr 0x05 ----------------
        tick();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h05; r0_wdata = 32'h1234_5678; r0_wmask = 4'h3;
        @(negedge clk); chk1("wr_gnt", r0_gnt, 1'b1);
        tick(); clear_reqs();
        @(negedge clk);
        chk1("wr_csb0", csb0, 1'b0);
        chk1("wr_web0", web0, 1'b0);
        chk32("wr_wmask0", 32'(wmask0), 32'h3);
        chk32("wr_din0", din0, 32'h1234_5678);
        chk32("wr_addr0", 32'(addr0), 32'h05);
        for (int i = 0; i < 4; i++) begin
            tick(); @(negedge clk);
            chk1("wr_no_rvalid", r0_rvalid | r1_rvalid, 1'b0);
        end
        $display("write r0 addr=05 data=12345678 wmask=3");

        // ---------------- enable drop with read in flight ----------------
        tick();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h33;
        @(negedge clk); chk1("dr_gnt0", r0_gnt, 1'b1);
        tick(); clear_reqs(); enable = 1'b0; r1_req = 1'b1; r1_addr = 8'h44;
        @(negedge clk); chk1("dr_no_gnt1_c1", r1_gnt, 1'b0);
        tick(); @(negedge clk);
        chk1("dr_no_gnt1_c2", r1_gnt, 1'b0);
        chk1("dr_busy_c2", busy, 1'b1);
        tick(); @(negedge clk);
        chk1("dr_rvalid0", r0_rvalid, 1'b1);
        chk1("dr_busy_c3", busy, 1'b1);
        chk1("dr_no_gnt1_c3", r1_gnt, 1'b0);
        tick(); r1_req = 1'b0; @(negedge clk);
        chk1("dr_busy_c4", busy, 1'b0);
        $display("drain: read returned, busy=%b", busy);

        // ---------------- reset in the middle of a read ----------------
        enable = 1'b1;
        tick();                                    // IDLE -> ACTIVE
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h55;
        @(negedge clk); chk1("mr_gnt", r0_gnt, 1'b1);
        tick(); clear_reqs();
        #1 resetn = 1'b0;
        #1;
        chk1("mr_csb0_async", csb0, 1'b1);
        chk1("mr_busy_async", busy, 1'b0);
        @(posedge clk); #1 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); @(negedge clk);
            chk1("mr_no_rvalid", r0_rvalid | r1_rvalid, 1'b0);
        end
        tick(); r0_req = 1'b1; r1_req = 1'b1; r0_addr = 8'h01; r1_addr = 8'h02;
        @(negedge clk);
        chk1("mr_tie_gnt0", r0_gnt, 1'b1);
        chk1("mr_tie_gnt1", r1_gnt, 1'b0);
        tick(); r0_req = 1'b0;
        @(negedge clk); chk1("mr_next_gnt1", r1_gnt, 1'b1);
        tick(); clear_reqs();
        $display("reset mid-read: first tie went to r0");

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        for (int i = 0; i < NR + LAT + 4; i++) begin
            rv_id[i] = -1;
            dout_hist[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; q_we[i] = 1'b0; q_addr[i] = '0; q_wdata[i] = '0; q_wmask[i] = '0;
        end
        m_state = 0; m_last = 1;
        e_csb = 1'b1; e_web = 1'b1; e_addr = '0; e_din = '0; e_wmask = '0; e_rdata = '0;

        for (int t = 0; t < NR; t++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]    = 1'b1;
                    q_we[i]    = 1'($urandom_range(0, 1));
                    q_addr[i]  = AW'($urandom);
                    q_wdata[i] = $urandom;
                    q_wmask[i] = MW'($urandom);
                end
            end
            if (t == 0) enable = 1'b1;
            else if ($urandom_range(0, 19) == 0) enable = ~enable;
            sram_dout    = $urandom;
            dout_hist[t] = sram_dout;
            r0_req = pend[0]; r0_we = q_we[0]; r0_addr = q_addr[0]; r0_wdata = q_wdata[0]; r0_wmask = q_wmask[0];
            r1_req = pend[1]; r1_we = q_we[1]; r1_addr = q_addr[1]; r1_wdata = q_wdata[1]; r1_wmask = q_wmask[1];

            g = -1;
            if (m_state == 1 && enable) begin
                if (pend[0] && pend[1]) g = (m_last == 1) ? 0 : 1;
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
            end
            m_empty = 1'b1;
            for (int k = t + 1; k <= t + LAT; k++)
                if (rv_id[k] >= 0) m_empty = 1'b0;
            if (rv_id[t] >= 0) e_rdata = dout_hist[t-1];

            @(negedge clk);
            chk1("rnd_gnt0", r0_gnt, g == 0);
            chk1("rnd_gnt1", r1_gnt, g == 1);
            chk1("rnd_csb0", csb0, e_csb);
            chk1("rnd_web0", web0, e_web);
            if (!e_csb) begin
                chk32("rnd_addr0", 32'(addr0), 32'(e_addr));
                chk32("rnd_din0", din0, e_din);
                chk32("rnd_wmask0", 32'(wmask0), 32'(e_wmask));
            end
            chk1("rnd_rvalid0", r0_rvalid, rv_id[t] == 0);
            chk1("rnd_rvalid1", r1_rvalid, rv_id[t] == 1);
            chk32("rnd_rdata", rdata, e_rdata);
            chk1("rnd_busy", busy, (m_state != 0) || !m_empty);

            if (g >= 0) begin
                $display("cyc %0d: grant r%0d %s addr=%h", t, g, q_we[g] ? "WR" : "RD", q_addr[g]);
                m_last  = g;
                pend[g] = 1'b0;
                e_csb   = 1'b0;
                e_web   = ~q_we[g];
                e_addr  = q_addr[g];
                e_din   = q_wdata[g];
                e_wmask = q_we[g] ? q_wmask[g] : '0;
                if (!q_we[g]) rv_id[t + 1 + LAT] = g;
            end else begin
                e_csb   = 1'b1;
                e_web   = 1'b1;
                e_wmask = '0;
            end
            case (m_state)
                0:       if (enable) m_state = 1;
                1:       if (!enable) m_state = 2;
                default: if (enable) m_state = 1; else if (m_empty) m_state = 0;
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
